// File: rtl/act_pkg.sv
// Shared definitions for the activation stage: mode encodings, FSM state type
// and a helper for the channel-index width.
package act_pkg;

  localparam logic [1:0] ACT_HTANH = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_HSIG  = 2'd2;
  localparam logic [1:0] ACT_SAT   = 2'd3;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } act_state_e;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/act_scalar.sv
// Single-channel activation: purely combinational x, mode -> y, sat.
// All comparisons are made on a sign-extended IN_W+1 bit copy of x so the
// hard-sigmoid intermediate cannot overflow.
module act_scalar import act_pkg::*; #(
  parameter int unsigned IN_W  = 48,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned FRAC  = 14
) (
  input  logic [IN_W-1:0]  x,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  localparam logic signed [IN_W:0] OneX    = (IN_W+1)'(1) << FRAC;
  localparam logic signed [IN_W:0] NegOneX = -OneX;
  localparam logic signed [IN_W:0] HalfX   = OneX >>> 1;
  localparam logic signed [IN_W:0] SatMaxX = ((IN_W+1)'(1) << (OUT_W-1)) - (IN_W+1)'(1);
  localparam logic signed [IN_W:0] SatMinX = -((IN_W+1)'(1) << (OUT_W-1));

  localparam logic [OUT_W-1:0] OneY    = OUT_W'(1) << FRAC;
  localparam logic [OUT_W-1:0] NegOneY = -OneY;
  localparam logic [OUT_W-1:0] SatMaxY = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SatMinY = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] xe;
  logic signed [IN_W:0] t;

  assign xe = $signed({x[IN_W-1], x});
  // Hard sigmoid: x/4 (floor) + 0.5.
  assign t  = (xe >>> 2) + HalfX;

  // Select the activation and flag whichever clamp branch was taken.
  always_comb begin
    y   = xe[OUT_W-1:0];
    sat = 1'b0;
    unique case (mode)
      ACT_HTANH: begin
        if (xe > OneX) begin
          y   = OneY;
          sat = 1'b1;
        end else if (xe < NegOneX) begin
          y   = NegOneY;
          sat = 1'b1;
        end
      end
      ACT_RELU: begin
        if (xe < 0) begin
          y   = '0;
          sat = 1'b1;
        end else if (xe > OneX) begin
          y   = OneY;
          sat = 1'b1;
        end
      end
      ACT_HSIG: begin
        y = t[OUT_W-1:0];
        if (t < 0) begin
          y   = '0;
          sat = 1'b1;
        end else if (t > OneX) begin
          y   = OneY;
          sat = 1'b1;
        end
      end
      ACT_SAT: begin
        if (xe > SatMaxX) begin
          y   = SatMaxY;
          sat = 1'b1;
        end else if (xe < SatMinX) begin
          y   = SatMinY;
          sat = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/act_unit.sv
// Multi-channel activation stage: latches a vector of accumulator values and
// emits one activated, saturated channel per cycle on a backpressurable stream.
// Optional feature: define ACT_SAT_COUNT_EN to add the saturation event counter
// (sat_count) and its synchronous clear (sat_clr).
module act_unit import act_pkg::*; #(
  parameter int unsigned IN_W     = 48,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned FRAC     = 14,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned ChW     = ch_width(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNELS*IN_W-1:0] in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [ChW-1:0]           out_ch,
  output logic                     out_last,
`ifdef ACT_SAT_COUNT_EN
  input  logic                     sat_clr,
  output logic [15:0]              sat_count,
`endif
  output logic                     out_sat
);

  localparam logic [ChW-1:0] LastCh = ChW'(CHANNELS - 1);

  act_state_e               state_q;
  logic [ChW-1:0]           ch_q;
  logic [CHANNELS*IN_W-1:0] data_q;
  logic [1:0]               mode_q;
  logic [IN_W-1:0]          x_sel;
  logic [OUT_W-1:0]         y;
  logic                     y_sat;
  logic                     load;

  assign in_ready = (state_q == StIdle);
  // Output register may take a new channel when empty or being drained.
  assign load     = (state_q == StRun) && (!out_valid || out_ready);
  assign x_sel    = data_q[IN_W*int'(ch_q) +: IN_W];

  act_scalar #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .FRAC  (FRAC)
  ) u_scalar (
    .x    (x_sel),
    .mode (mode_q),
    .y    (y),
    .sat  (y_sat)
  );

  // Control FSM with registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      data_q    <= '0;
      mode_q    <= ACT_HTANH;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q  <= in_data;
            mode_q  <= in_mode;
            ch_q    <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= y;
            out_ch    <= ch_q;
            out_last  <= (ch_q == LastCh);
            out_sat   <= y_sat;
            if (ch_q == LastCh) begin
              state_q <= StIdle;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ACT_SAT_COUNT_EN
  // Saturating count of clamped results; clear takes priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (load && y_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_unit.sv
// Self-checking bench for act_unit: directed vectors, back-to-back timing,
// backpressure, mid-vector reset and randomized traffic against a
// behavioural reference model.
module tb_act_unit;
  import act_pkg::*;

  localparam int unsigned IN_W  = 48;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned FRAC  = 14;
  localparam int unsigned CH    = 4;
  localparam longint ONE    = longint'(1) << FRAC;
  localparam longint SATMAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint SATMIN = -(longint'(1) << (OUT_W - 1));

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [CH*IN_W-1:0]   in_data;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [1:0]           out_ch;
  logic                 out_last;
  logic                 out_sat;
`ifdef ACT_SAT_COUNT_EN
  logic                 sat_clr;
  logic [15:0]          sat_count;
`endif

  act_unit #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .FRAC     (FRAC),
    .CHANNELS (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
`ifdef ACT_SAT_COUNT_EN
    .sat_clr   (sat_clr),
    .sat_count (sat_count),
`endif
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         mode;
    logic [CH*IN_W-1:0] data;
  } vec_t;

  typedef struct {
    int          ch;
    logic [15:0] data;
    bit          sat;
    longint      due;
    bit          seen;
  } res_t;

  int     checks = 0;
  int     errors = 0;
  vec_t   pend[$];
  res_t   expq[$];
  longint cyc = 0;
  int     sat_model = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [IN_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Activation rules in plain integer arithmetic.
  function automatic void ref_act(input longint x, input logic [1:0] mode,
                                  output logic [15:0] y, output bit sat);
    longint r;
    longint t;
    sat = 1'b0;
    r   = x;
    case (mode)
      ACT_HTANH: begin
        if (x > ONE) begin r = ONE; sat = 1'b1; end
        else if (x < -ONE) begin r = -ONE; sat = 1'b1; end
      end
      ACT_RELU: begin
        if (x < 0) begin r = 0; sat = 1'b1; end
        else if (x > ONE) begin r = ONE; sat = 1'b1; end
      end
      ACT_HSIG: begin
        t = x / 4;
        if (x < 0 && (x % 4) != 0) t = t - 1;
        t = t + ONE / 2;
        r = t;
        if (t < 0) begin r = 0; sat = 1'b1; end
        else if (t > ONE) begin r = ONE; sat = 1'b1; end
      end
      default: begin
        if (x > SATMAX) begin r = SATMAX; sat = 1'b1; end
        else if (x < SATMIN) begin r = SATMIN; sat = 1'b1; end
      end
    endcase
    y = r[15:0];
  endfunction

  function automatic longint rand_x();
    logic [63:0] r;
    longint      edges[16] = '{ONE, ONE + 1, -ONE, -ONE - 1, 0, -1, 'h8000, 'h8003,
                               'h8004, -'h8000, -'h8001, -'h7FFD, 32767, 32768,
                               -32768, -32769};
    case ($urandom_range(4, 0))
      0: begin
        r = {$urandom(), $urandom()};
        return sx(r[IN_W-1:0]);
      end
      1: return longint'($urandom_range(32'h20000, 0)) - 'h10000;
      2: return edges[$urandom_range(15, 0)];
      3: return longint'($urandom_range(32'h100000, 0)) - 'h80000;
      default: return longint'($urandom_range(32'h8000, 0)) - 'h4000;
    endcase
  endfunction

  task automatic push_vec(input logic [1:0] mode, input longint a, input longint b,
                          input longint c, input longint d);
    vec_t v;
    v.mode = mode;
    v.data[0*IN_W +: IN_W] = a[IN_W-1:0];
    v.data[1*IN_W +: IN_W] = b[IN_W-1:0];
    v.data[2*IN_W +: IN_W] = c[IN_W-1:0];
    v.data[3*IN_W +: IN_W] = d[IN_W-1:0];
    pend.push_back(v);
  endtask

  task automatic push_rand();
    push_vec(2'($urandom_range(3, 0)), rand_x(), rand_x(), rand_x(), rand_x());
  endtask

  // Offers every pending vector and drains all results. Called and returns
  // one sample point (#1 after a rising edge). stall_ch forces a 3-cycle
  // stall while that channel is presented; abort_ch returns as soon as that
  // channel is presented.
  task automatic run(input int stall_pct, input bit timed, input int stall_ch,
                     input int abort_ch);
    bit          adv = 1'b1;
    int          guard = 0;
    int          stall_left = 3;
    logic [15:0] ey;
    bit          es;
    vec_t        v;
    res_t        r;
    while (1) begin
      if (adv) begin
        adv = 1'b0;
        if (pend.size() > 0) begin
          in_valid = 1'b1;
          in_data  = pend[0].data;
          in_mode  = pend[0].mode;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        v = pend.pop_front();
        for (int c = 0; c < CH; c++) begin
          ref_act(sx(v.data[c*IN_W +: IN_W]), v.mode, ey, es);
          r.ch   = c;
          r.data = ey;
          r.sat  = es;
          r.due  = cyc + 2 + c;
          r.seen = 1'b0;
          expq.push_back(r);
        end
        adv = 1'b1;
      end
      if (abort_ch >= 0 && out_valid && expq.size() > 0 && expq[0].ch == abort_ch) return;
      if (stall_ch >= 0 && out_valid && expq.size() > 0 && expq[0].ch == stall_ch &&
          stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99, 0) >= stall_pct);
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!expq[0].seen) begin
            expq[0].seen = 1'b1;
            if (expq[0].sat && sat_model < 'hFFFF) sat_model++;
          end
          check("out_ch", 64'(out_ch), 64'(expq[0].ch));
          check("out_data", 64'(out_data), 64'(expq[0].data));
          check("out_sat", 64'(out_sat), 64'(expq[0].sat));
          check("out_last", 64'(out_last), 64'(expq[0].ch == CH - 1));
          if (expq[0].ch < CH - 1) check("in_ready_run", 64'(in_ready), 64'd0);
          if (timed) check("latency", 64'(cyc), 64'(expq[0].due));
`ifdef ACT_SAT_COUNT_EN
          check("sat_count", 64'(sat_count), 64'(sat_model));
`endif
          if (out_ready) void'(expq.pop_front());
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!adv && !in_valid && pend.size() == 0 && expq.size() == 0) break;
      guard++;
      if (guard > 2000) begin
        check("run_timeout", 64'(expq.size()), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    out_ready = 1'b0;
`ifdef ACT_SAT_COUNT_EN
    sat_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
`ifdef ACT_SAT_COUNT_EN
    check("rst_sat_count", 64'(sat_count), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with latency checked.
    push_vec(ACT_HTANH, 'h5000, -'h5000, 'h1234, 'h4000);
    run(0, 1'b1, -1, -1);
    push_vec(ACT_RELU, -5, 'h2000, 'h8000, 0);
    run(0, 1'b1, -1, -1);
    push_vec(ACT_HSIG, 0, 'h4000, 'h10000, -'h8004);
    run(0, 1'b1, -1, -1);
    push_vec(ACT_HSIG, -'h8000, -'h7FFD, 'h8000, 'h8004);
    run(0, 1'b1, -1, -1);
`ifdef ACT_SAT_COUNT_EN
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr   = 1'b0;
    sat_model = 0;
    check("sat_clr", 64'(sat_count), 64'd0);
`endif
    push_vec(ACT_SAT, 'h12345, -'h9000, 'h7FFF, -1);
    run(0, 1'b1, -1, -1);
`ifdef ACT_SAT_COUNT_EN
    check("satlin_count", 64'(sat_count), 64'd2);
`endif

    // Back-to-back vectors at full rate.
    repeat (3) push_rand();
    run(0, 1'b1, -1, -1);

    // Stall on channel 1 with the next vector offered early.
    push_vec(ACT_HTANH, 'h5000, -'h5000, 'h1234, 'h4000);
    push_rand();
    run(0, 1'b0, 1, -1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 8; i++) begin
      repeat (5) push_rand();
      run(35, 1'b0, -1, -1);
    end

    // Reset while channel 2 is presented.
    push_rand();
    run(0, 1'b0, -1, 2);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
`ifdef ACT_SAT_COUNT_EN
    check("abort_sat_count", 64'(sat_count), 64'd0);
`endif
    in_valid  = 1'b0;
    sat_model = 0;
    pend.delete();
    expq.delete();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    push_vec(ACT_RELU, -5, 'h2000, 'h8000, 0);
    run(0, 1'b1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
